// File: rtl/mpsoc_ahb4_pkg.sv
// Shared AHB4 (AHB-Lite) encodings and the initiator port state type.
package mpsoc_ahb4_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_ERR1 = 1'b1
   } ahb4_state_t;

endpackage

// File: rtl/mpsoc_ahb4_master_port.sv
// AHB4 initiator: valid/ready request stream to pipelined single transfers,
// one in-order response per request, with cancel/replay on two-cycle ERROR.
module mpsoc_ahb4_master_port
   import mpsoc_ahb4_pkg::*;
#(
   parameter int PLEN = 8,
   parameter int XLEN = 32
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [PLEN-1:0] req_addr,
   input  logic [2:0]      req_size,
   input  logic            req_lock,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_error,
   output logic            HSEL,
   output logic [PLEN-1:0] HADDR,
   output logic            HWRITE,
   output logic [2:0]      HSIZE,
   output logic [2:0]      HBURST,
   output logic [3:0]      HPROT,
   output logic [1:0]      HTRANS,
   output logic            HMASTLOCK,
   output logic [XLEN-1:0] HWDATA,
   input  logic [XLEN-1:0] HRDATA,
   input  logic            HREADY,
   input  logic            HRESP
);

   ahb4_state_t r_state, w_state_nxt;
   logic w_req_ready, w_err_start, w_replay, w_accept;

   logic [1:0]      r_htrans;
   logic [PLEN-1:0] r_haddr;
   logic            r_hwrite;
   logic [2:0]      r_hsize;
   logic            r_hlock;
   logic [XLEN-1:0] r_awdata;

   logic            r_dvalid;
   logic            r_dwrite;
   logic [XLEN-1:0] r_hwdata;

   logic            r_rp_valid;
   logic [PLEN-1:0] r_rp_addr;
   logic            r_rp_write;
   logic [2:0]      r_rp_size;
   logic            r_rp_lock;
   logic [XLEN-1:0] r_rp_wdata;

   logic            r_rsp_valid;
   logic [XLEN-1:0] r_rsp_rdata;
   logic            r_rsp_error;

   always_ff @(posedge HCLK) begin
      if (HRESET) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:  if (r_dvalid && HRESP && !HREADY) w_state_nxt = ST_ERR1;
         ST_ERR1: if (HREADY) w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_req_ready = 1'b0;
      w_err_start = 1'b0;
      w_replay    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_req_ready = HREADY & ~HRESET;
            w_err_start = r_dvalid & HRESP & ~HREADY;
         end
         ST_ERR1: w_replay = HREADY & r_rp_valid;
         default: ;
      endcase
   end

   assign w_accept  = req_valid & w_req_ready;
   assign req_ready = w_req_ready;

   // First ERROR cycle cancels the pending address phase even though HREADY=0.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_htrans <= HTRANS_IDLE;
         r_haddr  <= '0;
         r_hwrite <= 1'b0;
         r_hsize  <= '0;
         r_hlock  <= 1'b0;
         r_awdata <= '0;
      end else if (w_err_start) begin
         r_htrans <= HTRANS_IDLE;
      end else if (HREADY) begin
         if (w_replay) begin
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= r_rp_addr;
            r_hwrite <= r_rp_write;
            r_hsize  <= r_rp_size;
            r_hlock  <= r_rp_lock;
            r_awdata <= r_rp_wdata;
         end else if (w_accept) begin
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= req_addr;
            r_hwrite <= req_write;
            r_hsize  <= req_size;
            r_hlock  <= req_lock;
            r_awdata <= req_wdata;
         end else begin
            r_htrans <= HTRANS_IDLE;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_rp_valid <= 1'b0;
         r_rp_addr  <= '0;
         r_rp_write <= 1'b0;
         r_rp_size  <= '0;
         r_rp_lock  <= 1'b0;
         r_rp_wdata <= '0;
      end else if (w_err_start) begin
         r_rp_valid <= (r_htrans == HTRANS_NONSEQ);
         r_rp_addr  <= r_haddr;
         r_rp_write <= r_hwrite;
         r_rp_size  <= r_hsize;
         r_rp_lock  <= r_hlock;
         r_rp_wdata <= r_awdata;
      end else if (w_replay) begin
         r_rp_valid <= 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dvalid <= 1'b0;
         r_dwrite <= 1'b0;
         r_hwdata <= '0;
      end else if (HREADY) begin
         r_dvalid <= (r_htrans == HTRANS_NONSEQ);
         r_dwrite <= r_hwrite;
         if (r_htrans == HTRANS_NONSEQ) r_hwdata <= r_awdata;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
      end else begin
         r_rsp_valid <= HREADY & r_dvalid;
         if (HREADY && r_dvalid) begin
            r_rsp_rdata <= r_dwrite ? '0 : HRDATA;
            r_rsp_error <= HRESP;
         end
      end
   end

   assign HSEL      = r_htrans[1];
   assign HTRANS    = r_htrans;
   assign HADDR     = r_haddr;
   assign HWRITE    = r_hwrite;
   assign HSIZE     = r_hsize;
   assign HMASTLOCK = r_hlock;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DEFAULT;
   assign HWDATA    = r_hwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;

endmodule
